// File: rtl/canal_lock_sched_pkg.sv
// canal_lock_pkg: shared state and side encodings for the canal lock scheduler
package canal_lock_pkg;
  typedef enum logic [2:0] {IDLE, PREP, ENTER, XFER, EXIT} state_t;
  typedef enum logic {SIDE_W, SIDE_E} side_t;
endpackage

// File: rtl/canal_lock_sched_if.sv
// canal_lock_sched_if: boat requests/events in, gate and valve enables out
interface canal_lock_sched_if;
  logic req_w;
  logic req_e;
  logic entered;
  logic exited;
  logic gate_w_open;
  logic gate_e_open;
  logic fill_valve;
  logic drain_valve;
  logic grant_w;
  logic grant_e;
  logic level_hi;
  logic busy;
  modport master (
    output req_w, req_e, entered, exited,
    input  gate_w_open, gate_e_open, fill_valve, drain_valve, grant_w, grant_e, level_hi, busy
  );
  modport slave (
    input  req_w, req_e, entered, exited,
    output gate_w_open, gate_e_open, fill_valve, drain_valve, grant_w, grant_e, level_hi, busy
  );
endinterface

// File: rtl/canal_lock_sched_valve_timer.sv
// valve_timer: counts cycles since start; done on the n-th cycle of a valve run
module valve_timer #(
  parameter int TMR_W = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [TMR_W:0] n,
  output logic           done
);
  logic [TMR_W-1:0] count_q, count_d;
  // restart from zero when a valve run begins, otherwise free-run
  always_comb count_d = start ? '0 : count_q + TMR_W'(1);
  // count register
  always_ff @(posedge clk)
    if (reset) count_q <= '0;
    else count_q <= count_d;
  assign done = {1'b0, count_q} == n - (TMR_W+1)'(1);
endmodule

// File: rtl/canal_lock_sched.sv
// canal_lock_sched: round-robin transit scheduler sequencing gates and valves of a two-gate lock
module canal_lock_sched
  import canal_lock_pkg::*;
#(
  parameter int FILL_CYCLES  = 8,
  parameter int DRAIN_CYCLES = 8,
  parameter int TMR_W        = 4
) (
  input logic clk,
  input logic reset,
  canal_lock_sched_if.slave bus
);
  localparam logic [TMR_W:0] FILL_N  = (TMR_W+1)'(FILL_CYCLES);
  localparam logic [TMR_W:0] DRAIN_N = (TMR_W+1)'(DRAIN_CYCLES);
  state_t state_q, state_d;
  side_t dir_q, dir_d, last_q, last_d;
  logic level_q, level_d;
  logic tmr_start, tmr_done, filling, draining, gate_dir, gate_opp;
  // an empty chamber is adjusted towards the entry side in PREP, a loaded one towards the far side in XFER
  assign filling  = (state_q == PREP && dir_q == SIDE_E) || (state_q == XFER && dir_q == SIDE_W);
  assign draining = (state_q == PREP && dir_q == SIDE_W) || (state_q == XFER && dir_q == SIDE_E);
  assign gate_dir = state_q == ENTER;
  assign gate_opp = state_q == EXIT;
  valve_timer #(.TMR_W(TMR_W)) u_tmr (
    .clk(clk),
    .reset(reset),
    .start(tmr_start),
    .n(filling ? FILL_N : DRAIN_N),
    .done(tmr_done)
  );
  // next-state: arbitration in IDLE, then the fixed transit sequence
  always_comb begin
    state_d = state_q;
    dir_d = dir_q;
    last_d = last_q;
    level_d = level_q;
    case (state_q)
      IDLE: if (bus.req_w || bus.req_e) begin
        dir_d = (bus.req_w && bus.req_e) ? (last_q == SIDE_E ? SIDE_W : SIDE_E) : (bus.req_w ? SIDE_W : SIDE_E);
        state_d = (level_q == (dir_d == SIDE_E)) ? ENTER : PREP;
      end
      PREP: if (tmr_done) begin
        level_d = ~level_q;
        state_d = ENTER;
      end
      ENTER: if (bus.entered) state_d = XFER;
      XFER: if (tmr_done) begin
        level_d = ~level_q;
        state_d = EXIT;
      end
      EXIT: if (bus.exited) begin
        last_d = dir_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    tmr_start = (state_d == PREP && state_q != PREP) || (state_d == XFER && state_q != XFER);
  end
  // state registers; the chamber is assumed low after reset
  always_ff @(posedge clk)
    if (reset) begin
      state_q <= IDLE;
      dir_q <= SIDE_W;
      last_q <= SIDE_E;
      level_q <= 1'b0;
    end else begin
      state_q <= state_d;
      dir_q <= dir_d;
      last_q <= last_d;
      level_q <= level_d;
    end
  assign bus.gate_w_open = (gate_dir && dir_q == SIDE_W) || (gate_opp && dir_q == SIDE_E);
  assign bus.gate_e_open = (gate_dir && dir_q == SIDE_E) || (gate_opp && dir_q == SIDE_W);
  assign bus.fill_valve  = filling;
  assign bus.drain_valve = draining;
  assign bus.busy        = state_q != IDLE;
  assign bus.grant_w     = bus.busy && dir_q == SIDE_W;
  assign bus.grant_e     = bus.busy && dir_q == SIDE_E;
  assign bus.level_hi    = level_q;
endmodule

// File: doc/canal_lock_sched.md
Name: canal_lock_sched

Overview:
- Scheduler for the two-gate canal lock. It arbitrates between boats waiting at the west (low-water) gate and the east (high-water) gate.
- It sequences gate opening, chamber fill/drain and boat entry/exit so that the chamber is only ever entered or left at a matching water level.
- It sits above the per-gate controllers and drives their gate and valve enables.

Parameters:
- FILL_CYCLES, 8: cycles fill_valve is held high to raise the chamber from low to high.
- DRAIN_CYCLES, 8: cycles drain_valve is held high to lower the chamber from high to low.
- TMR_W, 4: timer width. Must satisfy 2**TMR_W >= max(FILL_CYCLES, DRAIN_CYCLES).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high.
- req_w  in  1  boat waiting at west gate (level-sensitive).
- req_e  in  1  boat waiting at east gate (level-sensitive).
- entered  in  1  pulse: boat fully inside chamber.
- exited  in  1  pulse: boat fully clear of chamber.
- gate_w_open  out  1  open west gate.
- gate_e_open  out  1  open east gate.
- fill_valve  out  1  open fill valve.
- drain_valve  out  1  open drain valve.
- grant_w  out  1  current transit is westbound-entry (boat entered from west).
- grant_e  out  1  current transit entered from east.
- level_hi  out  1  chamber water is at east (high) level.
- busy  out  1  transit in progress (state != IDLE).

Behaviour:
- Reset: state IDLE, level_hi=0, timer=0, dir=W, last_served=E. All outputs 0.
- Outputs are Moore, decoded from registered state/dir/level. A state change at edge t is visible after edge t.
- States and transitions:
  - IDLE: arbitrate. Only req_w -> dir=W. Only req_e -> dir=E. Both -> the side != last_served (round-robin; first tie after reset goes to W). If the required level matches (W needs level_hi=0, E needs level_hi=1) go to ENTER, else go to PREP. No request: stay.
  - PREP: empty-chamber adjust. dir=E: fill_valve=1 for exactly FILL_CYCLES cycles. dir=W: drain_valve=1 for exactly DRAIN_CYCLES cycles. On the last cycle toggle level_hi and go to ENTER.
  - ENTER: gate on dir side open. On entered=1 go to XFER.
  - XFER: adjust to the opposite level. dir=W fills (FILL_CYCLES), dir=E drains (DRAIN_CYCLES). On the last cycle toggle level_hi and go to EXIT.
  - EXIT: opposite gate open. On exited=1 set last_served=dir and go to IDLE.
- Timer: cleared on entry to PREP/XFER, increments each cycle. Terminal condition is count == N-1, so the valve is high exactly N cycles.
- grant_w/grant_e: high while busy, per dir. Both 0 in IDLE.
- Requests are sampled only in IDLE. Dropping a request after grant does not abort the transit.
- entered is ignored outside ENTER. exited is ignored outside EXIT.
- Safety invariants, always: never both gates open; never a valve open while any gate is open; never fill_valve and drain_valve together.
- Reset mid-operation: next cycle IDLE with all outputs 0 and level_hi=0. The chamber is treated as low after reset.
- Simultaneous entered and exited in ENTER: only entered acts.

Decomposition:
- Package canal_lock_pkg: state enum {IDLE, PREP, ENTER, XFER, EXIT}; side enum {SIDE_W, SIDE_E}.
- Sub-module valve_timer (start, N, done; TMR_W counter) is instantiated once and shared by PREP and XFER.

Test Plan:
1. Reset, then req_w=1 for 1 cycle.
   - Next cycle: gate_w_open=1, grant_w=1, busy=1.
   - Pulse entered: gate closes, fill_valve=1 for 8 cycles, then level_hi=1 and gate_e_open=1.
   - Pulse exited: busy=0, all gates and valves 0.
2. Reset, req_e=1 (level low).
   - fill_valve=1 for 8 cycles with both gates 0, then gate_e_open=1, grant_e=1.
   - After entered: drain 8 cycles, gate_w_open=1, level_hi=0.
3. Reset, req_w=req_e=1 held.
   - West served first.
   - After exited: east granted immediately with no PREP (level_hi=1 matches), gate_e_open one cycle after IDLE.
4. entered pulsed during PREP and exited pulsed during ENTER: no state change. The valve cycle count stays exactly 8.
5. reset asserted on cycle 3 of XFER: next cycle all outputs 0, level_hi=0, busy=0. A new req_w proceeds normally.
6. 2000 cycles of random req/entered/exited pulses with safety invariants asserted every cycle.
   - Zero violations.
   - Each valve assertion run length is exactly FILL_CYCLES or DRAIN_CYCLES.
